// File: rtl/tdm_demux_16_pkg.sv
// Shared definitions for the 16-channel TDM demultiplexer: channel count,
// counter width, frame FSM states and small channel-counter helpers.
package tdm_demux_16_pkg;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;

  // Channel index of the final slot in a frame; writing it ends the frame.
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Frame-mode sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Advance the channel counter; wraps naturally from LAST_CH back to 0.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return c + CH_W'(1);
  endfunction

  // True when the given channel is the final slot of a frame.
  function automatic logic is_last_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH);
  endfunction

endpackage

// File: rtl/tdm_demux_16_demux_1x4.sv
// One-to-four combinational demultiplexer. Used as the building block of
// the hierarchical one-hot write-enable decoder in tdm_demux_16.
module demux_1x4 (
  input  logic       en,
  input  logic [1:0] s,
  output logic [3:0] y
);

  // Route the enable onto the selected output; every other output is low.
  always_comb begin
    y    = 4'b0000;
    y[s] = en;
  end

endmodule

// File: rtl/tdm_demux_16.sv
// 16-channel, 1-bit-per-channel TDM demultiplexer. In addressed mode each
// valid bit lands on the channel named by sel; in frame mode a start pulse
// opens a frame and successive valid bits fill channels 0..15 in order.
module tdm_demux_16
  import tdm_demux_16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic [CH_W-1:0]   sel,
  input  logic              mode,
  input  logic              start,
  input  logic              clr,
  output logic [NUM_CH-1:0] out,
  output logic [CH_W-1:0]   ch,
  output logic              busy,
  output logic              frame_done
);

  state_t              state;
  logic                wr_req;
  logic [CH_W-1:0]     wr_addr;
  logic [3:0]          grp_en;
  logic [NUM_CH-1:0]   wr_en;
  logic [NUM_CH-1:0]   out_next;

  // Choose the write target: sel while idle in addressed mode, the counter
  // while collecting a frame; DONE and idle frame-mode cycles never write.
  always_comb begin
    wr_addr = sel;
    wr_req  = 1'b0;
    unique case (state)
      IDLE: begin
        wr_req = din_valid && !mode;
      end
      COLLECT: begin
        wr_addr = ch;
        wr_req  = din_valid;
      end
      default: begin
        wr_req = 1'b0;
      end
    endcase
  end

  // Upper select bits pick one group of four channels.
  demux_1x4 u_dec_hi (
    .en (wr_req),
    .s  (wr_addr[3:2]),
    .y  (grp_en)
  );

  // Lower select bits pick the channel inside each group.
  for (genvar g = 0; g < 4; g++) begin : g_dec_lo
    demux_1x4 u_dec_lo (
      .en (grp_en[g]),
      .s  (wr_addr[1:0]),
      .y  (wr_en[g*4 +: 4])
    );
  end

  // Merge the incoming bit into the enabled channel and hold all others.
  always_comb begin
    out_next = (out & ~wr_en) | (wr_en & {NUM_CH{din}});
  end

  // Frame FSM with registered outputs; clr outranks start and din_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out        <= '0;
      ch         <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      out        <= '0;
      ch         <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out <= out_next;
      unique case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (mode && start) begin
            state <= COLLECT;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (din_valid) begin
            if (is_last_ch(ch)) begin
              ch         <= '0;
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              ch <= next_ch(ch);
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_16.sv
// Self-checking bench for tdm_demux_16: a constant vector table for
// addressed mode, then hand-written frame sequences scored against a
// behavioural reference model through an expected-result queue.
module tb_tdm_demux_16;
  import tdm_demux_16_pkg::*;

  typedef struct packed {
    logic       din;
    logic       din_valid;
    logic [3:0] sel;
    logic       mode;
    logic       start;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  ch;
    logic        busy;
    logic        frame_done;
  } resp_t;

  typedef struct packed {
    stim_t stim;
    resp_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] out;
  logic [3:0]  ch;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  resp_t  sb_q[$];
  state_t m_state;
  resp_t  m;
  vec_t   vecs[10];

  always #5 clk = ~clk;

  tdm_demux_16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sel        (sel),
    .mode       (mode),
    .start      (start),
    .clr        (clr),
    .out        (out),
    .ch         (ch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Keep the run bounded even if a sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic d, input logic v, input logic [3:0] s,
                               input logic md, input logic st, input logic c);
    stim_t r;
    r.din = d; r.din_valid = v; r.sel = s; r.mode = md; r.start = st; r.clr = c;
    return r;
  endfunction

  function automatic resp_t mkr(input logic [15:0] o, input logic [3:0] c,
                                input logic b, input logic fd);
    resp_t r;
    r.out = o; r.ch = c; r.busy = b; r.frame_done = fd;
    return r;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_state = IDLE;
    m = '0;
  endtask

  // Reference behaviour of one rising edge.
  task automatic modelStep(input stim_t s);
    if (s.clr) begin
      modelReset();
    end else begin
      case (m_state)
        IDLE: begin
          m.frame_done = 1'b0;
          if (s.mode && s.start) begin
            m_state = COLLECT; m.ch = 4'd0; m.busy = 1'b1;
          end else if (!s.mode && s.din_valid) begin
            m.out[s.sel] = s.din;
          end
        end
        COLLECT: begin
          if (s.din_valid) begin
            m.out[m.ch] = s.din;
            if (m.ch == 4'd15) begin
              m.ch = 4'd0; m_state = DONE; m.busy = 1'b0; m.frame_done = 1'b1;
            end else begin
              m.ch = m.ch + 4'd1;
            end
          end
        end
        default: begin
          m.frame_done = 1'b0; m_state = IDLE;
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    resp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      checkField("out", 32'(out), 32'(e.out));
      checkField("ch", 32'(ch), 32'(e.ch));
      checkField("busy", 32'(busy), 32'(e.busy));
      checkField("frame_done", 32'(frame_done), 32'(e.frame_done));
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, score after the edge.
  task automatic applyStimulus(input stim_t s, input bit has_exp, input resp_t e);
    @(negedge clk);
    din = s.din; din_valid = s.din_valid; sel = s.sel;
    mode = s.mode; start = s.start; clr = s.clr;
    modelStep(s);
    sb_q.push_back(has_exp ? e : m);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step(input stim_t s);
    applyStimulus(s, 1'b0, '0);
  endtask

  // One frame: start, 16 data bits with optional idle gaps, then one idle cycle.
  task automatic runFrame(input logic [15:0] data, input int ngaps, input bit scramble,
                          output int cycles, output int dones);
    bit gap_before[16];
    int placed;
    int p;
    int t;
    logic [3:0] s;
    logic md;
    placed = 0; t = 0; cycles = 0; dones = 0;
    for (int i = 0; i < 16; i++) gap_before[i] = 1'b0;
    while (placed < ngaps) begin
      p = $urandom_range(15, 0);
      if (!gap_before[p]) begin gap_before[p] = 1'b1; placed++; end
    end
    step(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0));
    t++;
    if (frame_done) dones++;
    for (int i = 0; i < 16; i++) begin
      s  = scramble ? 4'($urandom_range(15, 0)) : 4'd0;
      md = scramble ? 1'($urandom_range(1, 0)) : 1'b1;
      if (gap_before[i]) begin
        step(mk(1'($urandom_range(1, 0)), 1'b0, s, md, 1'b0, 1'b0));
        t++;
        if (frame_done) begin dones++; if (cycles == 0) cycles = t; end
      end
      step(mk(data[i], 1'b1, s, md, 1'b0, 1'b0));
      t++;
      if (frame_done) begin dones++; if (cycles == 0) cycles = t; end
    end
    step(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
    if (frame_done) dones++;
  endtask

  initial begin
    int base_cycles;
    int gap_cycles;
    int dones;

    // Addressed-mode vectors with hand-derived expectations.
    vecs[0] = '{mk(1, 1, 4'd2,  0, 0, 0), mkr(16'h0004, 0, 0, 0)};
    vecs[1] = '{mk(1, 1, 4'd5,  0, 0, 0), mkr(16'h0024, 0, 0, 0)};
    vecs[2] = '{mk(1, 1, 4'd15, 0, 0, 0), mkr(16'h8024, 0, 0, 0)};
    vecs[3] = '{mk(0, 0, 4'd15, 0, 0, 0), mkr(16'h8024, 0, 0, 0)};
    vecs[4] = '{mk(0, 1, 4'd5,  0, 0, 0), mkr(16'h8004, 0, 0, 0)};
    vecs[5] = '{mk(1, 1, 4'd0,  1, 0, 0), mkr(16'h8004, 0, 0, 0)};
    vecs[6] = '{mk(1, 1, 4'd0,  0, 0, 0), mkr(16'h8005, 0, 0, 0)};
    vecs[7] = '{mk(1, 1, 4'd3,  0, 0, 1), mkr(16'h0000, 0, 0, 0)};
    vecs[8] = '{mk(1, 1, 4'd3,  0, 0, 0), mkr(16'h0008, 0, 0, 0)};
    vecs[9] = '{mk(0, 0, 4'd0,  0, 0, 1), mkr(16'h0000, 0, 0, 0)};

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    sb_q.push_back(m);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] addressed table");
    for (int i = 0; i < 10; i++) begin
      modelStep(vecs[i].stim);
      @(negedge clk);
      din = vecs[i].stim.din; din_valid = vecs[i].stim.din_valid; sel = vecs[i].stim.sel;
      mode = vecs[i].stim.mode; start = vecs[i].stim.start; clr = vecs[i].stim.clr;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      checkOutput();
    end

    $display("[TB] full frame");
    runFrame(16'h5555, 0, 1'b0, base_cycles, dones);
    checkField("frame_out", 32'(out), 32'h5555);
    checkField("frame_done_count", 32'(dones), 32'd1);
    checkField("frame_busy_after", 32'(busy), 32'd0);
    checkField("frame_ch_after", 32'(ch), 32'd0);
    checkField("frame_latency", 32'(base_cycles), 32'd17);

    $display("[TB] frame with gaps");
    runFrame(16'h5555, 3, 1'b0, gap_cycles, dones);
    checkField("gap_out", 32'(out), 32'h5555);
    checkField("gap_done_count", 32'(dones), 32'd1);
    checkField("gap_delay", 32'(gap_cycles), 32'(base_cycles + 3));

    $display("[TB] reset mid-frame");
    step(mk(0, 0, 0, 1, 0, 1));
    step(mk(0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 7; i++) step(mk(1, 1, 0, 1, 0, 0));
    checkField("pre_reset_out", 32'(out), 32'h007f);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkField("async_reset_out", 32'(out), 32'h0);
    checkField("async_reset_busy", 32'(busy), 32'd0);
    checkField("async_reset_ch", 32'(ch), 32'd0);
    @(posedge clk);
    #1;
    checkField("held_reset_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(mk(1, 1, 4'(i), 1, 0, 0));
    runFrame(16'ha5c3, 0, 1'b1, base_cycles, dones);
    checkField("post_reset_out", 32'(out), 32'ha5c3);
    checkField("post_reset_done_count", 32'(dones), 32'd1);

    $display("[TB] clr and start priority");
    step(mk(0, 0, 0, 1, 0, 1));
    step(mk(0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) step(mk(1, 1, 0, 1, 0, 0));
    step(mk(1, 1, 0, 1, 0, 1));
    checkField("clr_out", 32'(out), 32'h0);
    checkField("clr_busy", 32'(busy), 32'd0);
    step(mk(1, 1, 0, 1, 1, 0));
    checkField("start_discard_out", 32'(out), 32'h0);
    step(mk(0, 1, 0, 1, 0, 0));
    step(mk(1, 1, 0, 1, 0, 0));
    checkField("first_bits_out", 32'(out), 32'h0002);
    for (int i = 2; i < 16; i++) step(mk(0, 1, 0, 1, 0, 0));
    step(mk(0, 0, 0, 1, 0, 0));

    $display("[TB] start ignored mid-frame");
    step(mk(0, 0, 0, 1, 0, 1));
    step(mk(0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 9; i++) step(mk(0, 1, 0, 1, 0, 0));
    checkField("ch_before_start", 32'(ch), 32'd9);
    step(mk(1, 1, 0, 1, 1, 0));
    checkField("ch_after_start", 32'(ch), 32'd10);
    checkField("busy_after_start", 32'(busy), 32'd1);
    for (int i = 10; i < 16; i++) step(mk(1, 1, 0, 1, 0, 0));
    checkField("ignored_start_out", 32'(out), 32'hfe00);
    step(mk(0, 0, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
